// File: rtl/bec_key_sched_if.sv
// bec_key_sched_if
// Bundles the host-side and core-side signals of the key scheduler.
//   Host side : start, abort, key_in -> ; wout, zout, res_valid, busy, err, bit_cnt <- ; res_ack ->
//   Core side : core_enable, core_ki <- ; core_next_key, core_done, core_wout, core_zout ->
// Modports:
//   slave  - the scheduler itself
//   master - whatever drives the scheduler (host front end plus core, or a bench)
interface bec_key_sched_if #(
  parameter int KEY_BITS = 163,
  parameter int W        = 163,
  parameter int CNT_W    = 8
);
  logic                start;
  logic                abort;
  logic [KEY_BITS-1:0] key_in;
  logic                core_enable;
  logic                core_ki;
  logic                core_next_key;
  logic                core_done;
  logic [W-1:0]        core_wout;
  logic [W-1:0]        core_zout;
  logic [W-1:0]        wout;
  logic [W-1:0]        zout;
  logic                res_valid;
  logic                res_ack;
  logic                busy;
  logic [1:0]          err;
  logic [CNT_W-1:0]    bit_cnt;

  modport slave (
    input  start, abort, key_in, core_next_key, core_done, core_wout, core_zout, res_ack,
    output core_enable, core_ki, wout, zout, res_valid, busy, err, bit_cnt
  );

  modport master (
    output start, abort, key_in, core_next_key, core_done, core_wout, core_zout, res_ack,
    input  core_enable, core_ki, wout, zout, res_valid, busy, err, bit_cnt
  );
endinterface

// File: rtl/bec_key_sched.sv
// bec_key_sched
// Sequencer for the sm_bec_v3 scalar-multiplication core. Holds the scalar,
// presents one key bit per step on core_ki, shifts on every core_next_key
// pulse, counts consumed bits, gates the core enable and captures the core
// result for the host under a res_valid/res_ack handshake.
// Ports:
//   clk   - single clock
//   rst_n - asynchronous active-low reset
//   bus   - bec_key_sched_if.slave (host and core signals)
// Error codes on err: 00 none, 01 count mismatch, 10 overrun, 11 timeout.
// Optional feature macro: SCHED_TIMEOUT_EN enables a RUN-state watchdog of
// TIMEOUT_CYCLES cycles; without it RUN waits for the core indefinitely.
module bec_key_sched #(
  parameter int KEY_BITS       = 163,
  parameter int W              = 163,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input logic            clk,
  input logic            rst_n,
  bec_key_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, ERR} state_t;

  localparam logic [1:0]       ERR_NONE    = 2'b00;
  localparam logic [1:0]       ERR_COUNT   = 2'b01;
  localparam logic [1:0]       ERR_OVERRUN = 2'b10;
  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(KEY_BITS);

  // Elaboration-time sanity checks on the configuration.
  if ((64'd1 << CNT_W) <= 64'(KEY_BITS)) begin : g_bad_cnt_w
    $error("bec_key_sched: CNT_W too narrow to count KEY_BITS");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("bec_key_sched: TIMEOUT_CYCLES must be positive");
  end

  state_t              state_q, state_d;
  logic [KEY_BITS-1:0] keyReg_q, keyReg_d;
  logic [CNT_W-1:0]    bitCnt_q, bitCnt_d, cntPost;
  logic [W-1:0]        wout_q, wout_d, zout_q, zout_d;
  logic [1:0]          err_q, err_d;
  logic                coreEnable_q, resValid_q, busy_q;

`ifdef SCHED_TIMEOUT_EN
  localparam int         WD_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            wdogExpired;
  // The wdog_q value seen during the Nth RUN cycle is N-1.
  assign wdogExpired = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif

  // Next-state logic. abort overrides everything; otherwise each state only
  // reacts to the events relevant to it, the rest are ignored.
  always_comb begin
    state_d  = state_q;
    keyReg_d = keyReg_q;
    bitCnt_d = bitCnt_q;
    wout_d   = wout_q;
    zout_d   = zout_q;
    err_d    = err_q;
    // Count the done check must see when next_key lands in the same cycle.
    cntPost  = bitCnt_q + CNT_W'(bus.core_next_key);
`ifdef SCHED_TIMEOUT_EN
    wdog_d   = wdog_q;
`endif
    if (bus.abort) begin
      state_d  = IDLE;
      bitCnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            keyReg_d = bus.key_in;
            bitCnt_d = '0;
            err_d    = ERR_NONE;
            state_d  = RUN;
`ifdef SCHED_TIMEOUT_EN
            wdog_d   = '0;
`endif
          end
        end
        RUN: begin
`ifdef SCHED_TIMEOUT_EN
          wdog_d = wdog_q + WD_W'(1);
`endif
          if (bus.core_next_key && (bitCnt_q == CNT_FULL)) begin
            // Extra step beyond the scalar width: freeze key and count.
            err_d   = ERR_OVERRUN;
            state_d = ERR;
          end else begin
            if (bus.core_next_key) begin
              keyReg_d = keyReg_q >> 1;
              bitCnt_d = cntPost;
            end
            if (bus.core_done) begin
              if (cntPost == CNT_FULL) begin
                wout_d  = bus.core_wout;
                zout_d  = bus.core_zout;
                state_d = HOLD;
              end else begin
                err_d   = ERR_COUNT;
                state_d = ERR;
              end
            end
`ifdef SCHED_TIMEOUT_EN
            else if (wdogExpired) begin
              err_d   = ERR_TIMEOUT;
              state_d = ERR;
            end
`endif
          end
        end
        HOLD: begin
          if (bus.res_ack) state_d = IDLE;
        end
        ERR: begin
          if (bus.res_ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers. The status outputs are decoded from the
  // next state so they appear registered one cycle after the event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      keyReg_q     <= '0;
      bitCnt_q     <= '0;
      wout_q       <= '0;
      zout_q       <= '0;
      err_q        <= ERR_NONE;
      coreEnable_q <= 1'b0;
      resValid_q   <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      wdog_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      keyReg_q     <= keyReg_d;
      bitCnt_q     <= bitCnt_d;
      wout_q       <= wout_d;
      zout_q       <= zout_d;
      err_q        <= err_d;
      coreEnable_q <= (state_d == RUN);
      resValid_q   <= (state_d == HOLD);
      busy_q       <= (state_d != IDLE);
`ifdef SCHED_TIMEOUT_EN
      wdog_q       <= wdog_d;
`endif
    end
  end

  assign bus.core_enable = coreEnable_q;
  assign bus.core_ki     = keyReg_q[0];
  assign bus.wout        = wout_q;
  assign bus.zout        = zout_q;
  assign bus.res_valid   = resValid_q;
  assign bus.busy        = busy_q;
  assign bus.err         = err_q;
  assign bus.bit_cnt     = bitCnt_q;

endmodule

// File: doc/bec_key_sched.md
Name: bec_key_sched

Overview:
- Sequencer for the sm_bec_v3 scalar-multiplication core.
- Owns the 163-bit scalar: presents one key bit at a time on ki, shifts on each core next_key pulse, counts consumed bits and gates the core enable.
- Captures wout/zout on done and holds them for the host under a valid/ack handshake.
- Sits between the LA/host register front end and the core, replacing ad-hoc key shifting in the wrapper.

Parameters:
- KEY_BITS, 163, scalar width; also the required number of next_key pulses per run.
- W, 163, coordinate width of wout/zout.
- CNT_W, 8, width of bit counter; must satisfy 2^CNT_W > KEY_BITS.
- TIMEOUT_CYCLES, 200000, watchdog limit in clk cycles (used only with SCHED_TIMEOUT_EN).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; accepted only in IDLE.
- abort  in  1  return to IDLE from any state.
- key_in  in  KEY_BITS  scalar, sampled on accepted start.
- core_enable  out  1  enable to core.
- core_ki  out  1  current key bit to core.
- core_next_key  in  1  core pulse: current bit consumed.
- core_done  in  1  core completion.
- core_wout  in  W  core result W.
- core_zout  in  W  core result Z.
- wout  out  W  held result W.
- zout  out  W  held result Z.
- res_valid  out  1  result held and valid.
- res_ack  in  1  host consumed result or error.
- busy  out  1  state != IDLE.
- err  out  2  00 none, 01 count mismatch, 10 overrun, 11 timeout.
- bit_cnt  out  CNT_W  key bits consumed in the current run.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; key_reg, bit_cnt, wout, zout, err all 0; core_enable=0, res_valid=0, busy=0.
- All outputs registered except core_ki = key_reg[0] (combinational from the register).
- States: IDLE, RUN, HOLD, ERR.
- IDLE:
  - start=1 -> key_reg<=key_in, bit_cnt<=0, err<=0, state->RUN.
  - core_enable=1 and busy=1 in the next cycle (1-cycle latency).
- RUN:
  - core_enable=1.
  - core_next_key=1: key_reg<=key_reg>>1 (zero fill), bit_cnt<=bit_cnt+1.
  - Overrun: core_next_key=1 while bit_cnt==KEY_BITS -> err<=10, state->ERR; key_reg and bit_cnt not updated.
  - core_done=1: the count check uses the post-increment bit_cnt when next_key occurs in the same cycle.
    - Count == KEY_BITS -> wout<=core_wout, zout<=core_zout, state->HOLD, res_valid<=1.
    - Otherwise -> err<=01, state->ERR; wout/zout unchanged.
  - core_enable deasserts the cycle after done is observed.
- HOLD:
  - core_enable=0, res_valid=1.
  - res_ack=1 -> res_valid<=0, state->IDLE; wout/zout retain their values until the next successful capture.
- ERR:
  - core_enable=0, res_valid=0, err held.
  - res_ack=1 -> state->IDLE, err retained until the next accepted start.
- abort=1 in any state:
  - state->IDLE, core_enable<=0, res_valid<=0, bit_cnt<=0.
  - wout/zout unchanged.
  - abort has priority over every other event in the same cycle.
- start outside IDLE is ignored, with no side effects.
- core_next_key/core_done outside RUN are ignored.
- res_ack outside HOLD/ERR is ignored.
- Reset asserted mid-run: immediate return to reset values; the core is de-enabled asynchronously.
- Ladder execution is key-value independent: no leading-zero skipping; exactly KEY_BITS steps are always expected.

Optional Feature:
- SCHED_TIMEOUT_EN defined:
  - Watchdog counter clears on entry to RUN and increments every RUN cycle.
  - Reaching TIMEOUT_CYCLES without core_done -> err<=11, state->ERR.
  - Same-cycle core_done wins over timeout.
- Undefined: no watchdog logic; RUN waits indefinitely and err never takes 11.

Test Plan:
- Normal run: key_in=163'h5, core model issues 163 next_key pulses then done with wout=163'h1234, zout=163'h5678 -> core_ki sequence 1,0,1,0...; bit_cnt=163; res_valid=1, wout=163'h1234, zout=163'h5678; res_ack -> IDLE, busy=0 next cycle.
- Same-cycle next_key+done on the 163rd pulse -> accepted, HOLD, err=00.
- Early done after 100 pulses -> err=01, res_valid stays 0, wout unchanged.
- 164th next_key pulse -> err=10, ERR state; res_ack -> IDLE; next start clears err to 00.
- abort at bit_cnt=50 concurrently with start -> IDLE next cycle, core_enable=0, bit_cnt=0; start during RUN ignored (key_reg unchanged).
- SCHED_TIMEOUT_EN with TIMEOUT_CYCLES=1000, core never asserts done -> err=11 at cycle 1000 of RUN; without the macro, still in RUN after 5000 cycles.
